vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
Timing generator that sits directly upstream of every page display block (title, game, done pages).
It divides the system clock to a pixel tick and runs horizontal/vertical counters for 640x480@60.
Its outputs drive the displays' video_on and x/y inputs, the monitor's hsync/vsync pins, and a frame_start pulse used by game logic.
Consumers sample x, y and video_on on clk, qualified by p_tick.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal 2..16
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, logic level of hsync/vsync during the sync pulse

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
p_tick  out  1  one-clk pulse once per pixel period
video_on  out  1  high while the counters are inside the visible area
hsync  out  1  horizontal sync to connector
vsync  out  1  vertical sync to connector
x  out  10  current horizontal count (h_count)
y  out  10  current vertical count (v_count)
frame_start  out  1  one-clk pulse when the counters wrap to (0,0)

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset; it is fixed.
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Counters are 10 bits wide.
- Reset (asserts immediately, independent of clk):
  - div_cnt = 0, h_count = 0, v_count = 0.
  - hsync = vsync = ~SYNC_ACTIVE.
  - frame_start = 0, p_tick = 0.
- Pixel divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt == CLK_DIV-1), decoded from the register.
  - After reset release, p_tick is first high in the cycle following the 3rd rising edge (CLK_DIV=4).
- Horizontal counter: advances only on a clk edge where p_tick = 1. h_count = H_TOTAL-1 wraps to 0; otherwise h_count + 1.
- Vertical counter: advances only on an edge where p_tick = 1 and h_count = H_TOTAL-1. v_count = V_TOTAL-1 wraps to 0; otherwise v_count + 1.
- x = h_count and y = v_count, taken directly from the registers (no extra latency).
- video_on = (h_count < H_DISPLAY) && (v_count < V_DISPLAY), combinational from the counters.
- hsync register: loaded with a decode of the next h_count value, so it is aligned with x.
  - SYNC_ACTIVE when H_DISPLAY+H_FRONT <= h_count < H_DISPLAY+H_FRONT+H_SYNC, i.e. x in 656..751.
- vsync register: same scheme on the next v_count.
  - SYNC_ACTIVE when V_DISPLAY+V_FRONT <= v_count < V_DISPLAY+V_FRONT+V_SYNC, i.e. y in 490..491.
- frame_start: registered. High for exactly one clk in the cycle in which (h_count, v_count) first equals (0,0) after a wrap from (799,524).
  - Not asserted after reset release; the first pulse comes at the first natural frame wrap.
- Counters hold their values on non-tick cycles, so x, y and video_on are stable for CLK_DIV clks.
- Reset asserted mid-frame: all state returns to reset values at once; counting restarts from (0,0) on release.
- No illegal states: any counter value at or above its total is unreachable. If forced, it wraps to 0 on the next qualifying tick.

Decomposition:
- Shared package vga_timing_pkg holds:
  - H_* / V_* default constants and derived H_TOTAL, V_TOTAL.
  - SYNC_ACTIVE default.
  - Text-area constants used by the page displays: char width 8, char height 16.
- One sub-module is natural: pixel_tick_gen (div_cnt and p_tick, parameterised by CLK_DIV, clk/reset).
- Counters and sync decode stay in vga_sync_gen.

Test Plan:
- Reset, then release: all outputs at reset values; hsync = vsync = 1; x = y = 0; video_on = 1. p_tick first high after edge 3; x = 1 after edge 4.
- Run to x = 639 then x = 640 (y = 0): video_on goes 1 -> 0; hsync stays 1 until x = 656, is 0 for x = 656..751 (96 ticks), and returns to 1 at x = 752.
- Line wrap at x = 799, y = 5, next tick: x = 0, y = 6. No y change on the ticks where x = 798 -> 799.
- Frame, y = 479 -> 480: video_on stays 0 for the whole line. vsync = 0 exactly for y = 490..491 (1600 ticks) and 1 otherwise.
- Wrap from (799,524) to (0,0): frame_start high for exactly one clk. Interval between pulses = 800*525*4 = 1,680,000 clks.
- Reset pulse asserted asynchronously mid-line at x = 300, y = 200, between clk edges: outputs go to reset values before the next edge. After release, the sequence is identical to the first test.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing constants and sync decode helper
package vga_timing_pkg;

  // Counter width shared by x/y and the page displays.
  localparam int COUNT_W = 10;

  // Pixel clock divider default: 100 MHz system clock down to 25 MHz.
  localparam int CLK_DIV_DEF = 4;

  // Horizontal timing in pixels.
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL       = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  // Vertical timing in lines.
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL       = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Monitor expects negative-going sync pulses at this mode.
  localparam logic SYNC_ACTIVE_DEF = 1'b0;

  // Text grid used by the page displays.
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;

  // Sync level for a counter value: active inside [start, stop), idle elsewhere.
  function automatic logic sync_level(input logic [COUNT_W-1:0] cnt,
                                      input logic [COUNT_W-1:0] start,
                                      input logic [COUNT_W-1:0] stop,
                                      input logic               active);
    return ((cnt >= start) && (cnt < stop)) ? active : ~active;
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// rtl/pixel_tick_gen.sv - divides clk down to a one-cycle pixel tick
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Free-running divider; values past the last step (never reached normally) also wrap to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt >= DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Tick is a decode of the register, so it is low while reset holds div_cnt at 0.
  assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - pixel/line counters and sync generation for the page displays
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV     = CLK_DIV_DEF,
  parameter int   H_DISPLAY   = H_DISPLAY_DEF,
  parameter int   H_FRONT     = H_FRONT_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BACK      = H_BACK_DEF,
  parameter int   V_DISPLAY   = V_DISPLAY_DEF,
  parameter int   V_FRONT     = V_FRONT_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BACK      = V_BACK_DEF,
  parameter logic SYNC_ACTIVE = SYNC_ACTIVE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOT - 1);
  localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOT - 1);
  localparam logic [COUNT_W-1:0] H_VIS    = COUNT_W'(H_DISPLAY);
  localparam logic [COUNT_W-1:0] V_VIS    = COUNT_W'(V_DISPLAY);
  localparam logic [COUNT_W-1:0] HS_START = COUNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [COUNT_W-1:0] HS_STOP  = COUNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [COUNT_W-1:0] VS_START = COUNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [COUNT_W-1:0] VS_STOP  = COUNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [COUNT_W-1:0] h_count;
  logic [COUNT_W-1:0] v_count;
  logic [COUNT_W-1:0] h_next;
  logic [COUNT_W-1:0] v_next;
  logic               h_end;
  logic               v_end;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  // Next counter values; out-of-range values count as "end" so they fall back to 0.
  always_comb begin
    h_end  = (h_count >= H_LAST);
    v_end  = (v_count >= V_LAST);
    h_next = h_count;
    v_next = v_count;
    if (p_tick) begin
      h_next = h_end ? '0 : h_count + 1'b1;
      if (h_end) begin
        v_next = v_end ? '0 : v_count + 1'b1;
      end
    end
  end

  // Counters plus syncs decoded from the next counts, so hsync/vsync line up with x/y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count     <= '0;
      v_count     <= '0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      h_count     <= h_next;
      v_count     <= v_next;
      hsync       <= sync_level(h_next, HS_START, HS_STOP, SYNC_ACTIVE);
      vsync       <= sync_level(v_next, VS_START, VS_STOP, SYNC_ACTIVE);
      frame_start <= p_tick && h_end && v_end;
    end
  end

  assign x        = h_count;
  assign y        = v_count;
  assign video_on = (h_count < H_VIS) && (v_count < V_VIS);

endmodule
